// File: rtl/demux_1x2_24bit_reg_if.sv
// Handshake bundle for demux_1x2_24bit_reg: one producer stream in, two consumer streams out.
// The slave modport is the demux side; the master modport is the producer/consumer side.
interface demux_1x2_24bit_reg_if #(
    parameter int WIDTH = 24
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             S;
    logic             a_valid;
    logic             a_ready;
    logic [WIDTH-1:0] a_data;
    logic             b_valid;
    logic             b_ready;
    logic [WIDTH-1:0] b_data;

    modport slave (
        input  in_valid, in_data, S, a_ready, b_ready,
        output in_ready, a_valid, a_data, b_valid, b_data
    );

    modport master (
        output in_valid, in_data, S, a_ready, b_ready,
        input  in_ready, a_valid, a_data, b_valid, b_data
    );
endinterface

// File: rtl/demux_1x2_24bit_reg.sv
// Registered 1-to-2 demux with a one-entry holding register per output.
// Defining DEMUX_1X2_COUNT_EN adds 16-bit a_count/b_count counters of completed dequeues.
module demux_1x2_24bit_reg #(
    parameter int WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  rst_n,
    demux_1x2_24bit_reg_if.slave  bus
`ifdef DEMUX_1X2_COUNT_EN
    ,
    output logic [15:0]           a_count,
    output logic [15:0]           b_count
`endif
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } slot_state_t;

    slot_state_t      a_state, a_state_nxt;
    slot_state_t      b_state, b_state_nxt;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             accept, a_load, b_load, a_deq, b_deq;

    // in_ready looks only at the selected slot, so a stalled consumer blocks only its own traffic.
    assign bus.in_ready = rst_n && (bus.S ? ((b_state == EMPTY) || bus.b_ready)
                                          : ((a_state == EMPTY) || bus.a_ready));

    assign accept = bus.in_valid && bus.in_ready;
    assign a_load = accept && !bus.S;
    assign b_load = accept && bus.S;
    assign a_deq  = (a_state == FULL) && bus.a_ready;
    assign b_deq  = (b_state == FULL) && bus.b_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_state <= EMPTY;
            b_state <= EMPTY;
        end else begin
            a_state <= a_state_nxt;
            b_state <= b_state_nxt;
        end
    end

    // A load wins over a dequeue, which gives reload-in-place at full throughput.
    always_comb begin
        a_state_nxt = a_state;
        b_state_nxt = b_state;
        if (a_load) begin
            a_state_nxt = FULL;
        end else if (a_deq) begin
            a_state_nxt = EMPTY;
        end
        if (b_load) begin
            b_state_nxt = FULL;
        end else if (b_deq) begin
            b_state_nxt = EMPTY;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
        end else begin
            if (a_load) begin
                a_reg <= bus.in_data;
            end
            if (b_load) begin
                b_reg <= bus.in_data;
            end
        end
    end

    assign bus.a_valid = (a_state == FULL);
    assign bus.b_valid = (b_state == FULL);
    assign bus.a_data  = a_reg;
    assign bus.b_data  = b_reg;

`ifdef DEMUX_1X2_COUNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_count <= '0;
            b_count <= '0;
        end else begin
            if (a_deq) begin
                a_count <= a_count + 16'd1;
            end
            if (b_deq) begin
                b_count <= b_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_demux_1x2_24bit_reg.sv
// Directed self-checking bench for demux_1x2_24bit_reg; counter checks run only when
// DEMUX_1X2_COUNT_EN is defined.
module tb_demux_1x2_24bit_reg;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    demux_1x2_24bit_reg_if #(.WIDTH(24)) bus ();

`ifdef DEMUX_1X2_COUNT_EN
    logic [15:0] a_count;
    logic [15:0] b_count;
`endif

    demux_1x2_24bit_reg #(.WIDTH(24)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus)
`ifdef DEMUX_1X2_COUNT_EN
        ,
        .a_count (a_count),
        .b_count (b_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic valid, input logic sel, input logic [23:0] data);
        bus.in_valid = valid;
        bus.S        = sel;
        bus.in_data  = data;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.a_ready = 1'b0;
        bus.b_ready = 1'b0;
        applyStimulus(1'b0, 1'b0, 24'd0);

        #2;
        checkOutput("por_in_ready", {31'd0, bus.in_ready}, 32'd0);
        checkOutput("por_a_valid", {31'd0, bus.a_valid}, 32'd0);
        step();
        rst_n = 1'b1;

        // Reset mid-stream while A holds 1
        applyStimulus(1'b1, 1'b0, 24'd1);
        step();
        checkOutput("pre_rst_a_valid", {31'd0, bus.a_valid}, 32'd1);
        checkOutput("pre_rst_a_data", {8'd0, bus.a_data}, 32'd1);
        applyStimulus(1'b0, 1'b0, 24'd0);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_a_valid", {31'd0, bus.a_valid}, 32'd0);
        checkOutput("rst_b_valid", {31'd0, bus.b_valid}, 32'd0);
        checkOutput("rst_a_data", {8'd0, bus.a_data}, 32'd0);
        checkOutput("rst_b_data", {8'd0, bus.b_data}, 32'd0);
        applyStimulus(1'b1, 1'b0, 24'd5);
        #1;
        checkOutput("rst_in_ready", {31'd0, bus.in_ready}, 32'd0);
        step();
        checkOutput("rst_hold_a_valid", {31'd0, bus.a_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 24'd0);
        rst_n = 1'b1;

        // Basic route
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 24'd1);
        #1;
        checkOutput("route_in_ready_a", {31'd0, bus.in_ready}, 32'd1);
        step();
        checkOutput("route_a_valid", {31'd0, bus.a_valid}, 32'd1);
        checkOutput("route_a_data", {8'd0, bus.a_data}, 32'd1);
        checkOutput("route_b_idle", {31'd0, bus.b_valid}, 32'd0);
        applyStimulus(1'b1, 1'b1, 24'd2);
        step();
        checkOutput("route_b_valid", {31'd0, bus.b_valid}, 32'd1);
        checkOutput("route_b_data", {8'd0, bus.b_data}, 32'd2);
        checkOutput("route_a_drained", {31'd0, bus.a_valid}, 32'd0);
        applyStimulus(1'b0, 1'b0, 24'd0);
        step();
        checkOutput("route_b_drained", {31'd0, bus.b_valid}, 32'd0);

        // Stall isolation: B stuck full, A traffic still flows
        bus.b_ready = 1'b0;
        applyStimulus(1'b1, 1'b1, 24'hABCDEF);
        step();
        checkOutput("stall_b_valid", {31'd0, bus.b_valid}, 32'd1);
        checkOutput("stall_b_data", {8'd0, bus.b_data}, 32'hABCDEF);
        applyStimulus(1'b1, 1'b1, 24'h111111);
        #1;
        checkOutput("stall_in_ready_b", {31'd0, bus.in_ready}, 32'd0);
        step();
        checkOutput("stall_b_hold_valid", {31'd0, bus.b_valid}, 32'd1);
        checkOutput("stall_b_hold_data", {8'd0, bus.b_data}, 32'hABCDEF);
        applyStimulus(1'b1, 1'b0, 24'h000123);
        #1;
        checkOutput("stall_in_ready_a", {31'd0, bus.in_ready}, 32'd1);
        step();
        checkOutput("stall_a_valid", {31'd0, bus.a_valid}, 32'd1);
        checkOutput("stall_a_data", {8'd0, bus.a_data}, 32'h000123);
        checkOutput("stall_b_still", {8'd0, bus.b_data}, 32'hABCDEF);

        // Back-to-back on A with reload-in-place
        for (int i = 1; i <= 8; i++) begin
            applyStimulus(1'b1, 1'b0, 24'(i));
            #1;
            checkOutput($sformatf("b2b_in_ready_%0d", i), {31'd0, bus.in_ready}, 32'd1);
            step();
            checkOutput($sformatf("b2b_a_valid_%0d", i), {31'd0, bus.a_valid}, 32'd1);
            checkOutput($sformatf("b2b_a_data_%0d", i), {8'd0, bus.a_data}, 32'(i));
        end

        // Drain A with a single ready pulse
        applyStimulus(1'b0, 1'b0, 24'h5A5A5A);
        step();
        bus.a_ready = 1'b0;
        checkOutput("drain_a_valid", {31'd0, bus.a_valid}, 32'd0);
        checkOutput("drain_a_data", {8'd0, bus.a_data}, 32'd8);
        step();
        checkOutput("drain_a_stable", {31'd0, bus.a_valid}, 32'd0);

`ifdef DEMUX_1X2_COUNT_EN
        rst_n = 1'b0;
        #1;
        checkOutput("cnt_rst_a", {16'd0, a_count}, 32'd0);
        checkOutput("cnt_rst_b", {16'd0, b_count}, 32'd0);
        step();
        rst_n = 1'b1;
        bus.a_ready = 1'b1;
        bus.b_ready = 1'b1;
        applyStimulus(1'b1, 1'b0, 24'd10);
        step();
        applyStimulus(1'b1, 1'b0, 24'd11);
        step();
        applyStimulus(1'b1, 1'b0, 24'd12);
        step();
        applyStimulus(1'b1, 1'b1, 24'd20);
        step();
        applyStimulus(1'b1, 1'b1, 24'd21);
        step();
        applyStimulus(1'b0, 1'b0, 24'd0);
        step();
        step();
        checkOutput("cnt_a_3", {16'd0, a_count}, 32'd3);
        checkOutput("cnt_b_2", {16'd0, b_count}, 32'd2);

        // 65532 more A words brings a_count to 65535
        applyStimulus(1'b1, 1'b0, 24'd7);
        for (int i = 0; i < 65532; i++) begin
            step();
        end
        applyStimulus(1'b0, 1'b0, 24'd0);
        step();
        step();
        checkOutput("cnt_a_max", {16'd0, a_count}, 32'd65535);
        applyStimulus(1'b1, 1'b0, 24'd9);
        step();
        applyStimulus(1'b0, 1'b0, 24'd0);
        step();
        step();
        checkOutput("cnt_a_wrap", {16'd0, a_count}, 32'd0);
        checkOutput("cnt_b_keep", {16'd0, b_count}, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/demux_1x2_24bit_reg.md
Name: demux_1x2_24bit_reg

Overview:
- Registered 1-to-2 demultiplexer for 24-bit mantissa words in the floating-point datapath; the counterpart of mux_2x1_24bit.
- Routes one producer stream to one of two consumers (A or B), selected by S.
- Uses a valid/ready handshake on every side.
- Each output has a one-entry holding register, so a stalled consumer does not block traffic bound for the other consumer.

Parameters:
- WIDTH, 24, data width in bits of in_data, a_data and b_data.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer presents a word.
- in_ready  output  1  demux accepts the word this cycle.
- in_data  input  WIDTH  word to route.
- S  input  1  destination select: 0 = A, 1 = B; sampled only on the accept cycle.
- a_valid  output  1  A holding register full.
- a_ready  input  1  consumer A takes the word this cycle.
- a_data  output  WIDTH  A holding register contents.
- b_valid  output  1  B holding register full.
- b_ready  input  1  consumer B takes the word this cycle.
- b_data  output  WIDTH  B holding register contents.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - a_valid=0, b_valid=0, a_data=0, b_data=0.
  - Any held words are discarded.
  - in_ready drops to 0 immediately and stays 0 until rst_n=1.
- Per-output state machine: EMPTY / FULL. The output valid is 1 exactly in FULL.
- in_ready (combinational, not registered):
  - S=0: !a_valid || a_ready.
  - S=1: !b_valid || b_ready.
  - 0 while in reset.
- Accept: in_valid && in_ready at a rising edge.
  - in_data is written to the selected register.
  - The selected output is FULL on the next cycle; latency is 1 clock.
- Dequeue on X (X = a or b): X_valid && X_ready at a rising edge.
  - X goes FULL -> EMPTY, unless an accept targets X in the same cycle.
- Simultaneous dequeue and accept on the same output:
  - The register reloads with the new word and stays FULL.
  - Full throughput is 1 word/cycle per output.
- EMPTY + accept -> FULL. FULL + dequeue without accept -> EMPTY. FULL with no dequeue -> data and valid hold stable.
- No accept occurs while in_valid=0; registers and states are unchanged.
- The non-selected output is never written. Its state evolves only by its own dequeue.
- Blocking: a stalled B (FULL, b_ready=0) blocks only words with S=1.
  - A producer presenting S=1 sees in_ready=0 and must hold in_valid, in_data and S stable until accepted.
- in_data and S are don't-care when in_valid=0.
- X_data keeps its last value after dequeue; it is not cleared.
- No combinational path from in_data to either data output.

Optional Feature:
- Macro: DEMUX_1X2_COUNT_EN.
- Defined: adds output ports a_count and b_count, each 16 bits.
  - Each counts completed dequeues on its side.
  - Resets to 0 and wraps from 65535 to 0.
  - Increments on the cycle after the dequeue edge is visible, i.e. a registered update.
- Not defined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst_n=0 mid-stream with a_valid=1 holding 24'd1.
  - Required: a_valid, b_valid, a_data and b_data are 0 without waiting for a clock edge.
  - Required: in_ready=0 during reset.
- Basic route, with a_ready=1 and b_ready=1:
  - Send 24'd1 with S=0, then 24'd2 with S=1.
  - Required: a_valid=1 and a_data=1 one cycle after the first accept.
  - Required: b_valid=1 and b_data=2 one cycle after the second accept.
  - Required: the other output's valid stays 0 each time.
- Stall isolation: set b_ready=0 and send 24'hABCDEF with S=1.
  - Required: B is FULL and holds hABCDEF stable.
  - Next word with S=1: in_ready=0.
  - Word 24'h000123 with S=0: accepted, and a_data=h000123 one cycle later.
- Back-to-back: a_ready=1, S=0, in_valid=1 for 8 cycles with data 1..8.
  - Required: in_ready=1 every cycle; a_data steps 1..8 on consecutive cycles; no bubbles.
- Drain: with A FULL, drop in_valid and pulse a_ready for 1 cycle.
  - Required: a_valid=0 next cycle and a_data retains its last value.
- Counter, with DEMUX_1X2_COUNT_EN defined: 3 dequeues on A and 2 on B.
  - Required: a_count=3, b_count=2.
  - Preload to 65535 via traffic, then one more dequeue: count wraps to 0.
